// File: rtl/mob_column_scheduler.sv
// Per-frame column walker: reads each ray entry, derives body/head/whole-mob
// heights with one shared restoring divider and writes a packed word per column.
module mob_column_scheduler #(
    parameter int NUM_COLS = 640,
    parameter int K_BODY   = 122880,
    parameter int K_HEAD   = 40960,
    parameter int K_ALL    = 163840
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [9:0]  ray_addr,
    input  logic [31:0] ray_q,
    output logic        prm_we,
    output logic [9:0]  prm_addr,
    output logic [42:0] prm_data
);
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_FETCH = 3'd1;
    localparam logic [2:0]  S_WAIT  = 3'd2;
    localparam logic [2:0]  S_LOAD  = 3'd3;
    localparam logic [2:0]  S_DIV   = 3'd4;
    localparam logic [2:0]  S_WRITE = 3'd5;
    localparam logic [2:0]  S_DONE  = 3'd6;
    localparam logic [9:0]  LAST_COL = 10'(NUM_COLS - 1);
    localparam logic [17:0] DVD_BODY = 18'(K_BODY);
    localparam logic [17:0] DVD_HEAD = 18'(K_HEAD);
    localparam logic [17:0] DVD_ALL  = 18'(K_ALL);
    localparam logic [11:0] H_SAT    = 12'hFFF;

    logic [2:0]  state_r;
    logic [9:0]  col_r;
    logic [15:0] dist_r;
    logic [1:0]  type_r;
    logic [3:0]  tex_r;
    logic [16:0] rem_r;
    logic [17:0] quo_r;
    logic [4:0]  bit_r;
    logic [1:0]  sel_r;
    logic [11:0] h_body_r;
    logic [11:0] h_head_r;
    logic        busy_r;
    logic        done_r;
    logic        prm_we_r;
    logic [9:0]  ray_addr_r;
    logic [9:0]  prm_addr_r;
    logic [42:0] prm_data_r;

    logic [17:0] trial_s;
    logic [16:0] diff_s;
    logic        ge_s;
    logic [16:0] rem_next_s;
    logic [17:0] quot_s;
    logic [11:0] quot_sat_s;
    logic [3:0]  tex_in_s;
    logic        last_bit_s;
    logic        unused_bits_s;

    function automatic logic [42:0] pack_word(input logic valid, input logic [1:0] mtype,
                                              input logic [3:0] tex, input logic [11:0] h_all,
                                              input logic [11:0] h_head, input logic [11:0] h_body);
        pack_word = {valid, mtype, tex, h_all, h_head, h_body};
    endfunction

    function automatic logic [11:0] sat12(input logic [17:0] q);
        if (q > 18'd4095) begin
            sat12 = H_SAT;
        end else begin
            sat12 = q[11:0];
        end
    endfunction

    // One restoring-division step plus the texture offset of the incoming entry.
    always_comb begin
        trial_s    = {rem_r, quo_r[17]};
        diff_s     = trial_s[16:0] - {1'b0, dist_r};
        ge_s       = (trial_s >= {2'b00, dist_r});
        if (ge_s) begin
            rem_next_s = diff_s;
        end else begin
            rem_next_s = trial_s[16:0];
        end
        quot_s     = {quo_r[16:0], ge_s};
        quot_sat_s = sat12(quot_s);
        tex_in_s   = ray_q[5:2] + 4'h8;
        last_bit_s = (bit_r == 5'd17);
    end

    assign unused_bits_s = ^ray_q[7:6];

    // Pass sequencing, divider iteration and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= S_IDLE;
            col_r      <= 10'd0;
            dist_r     <= 16'd0;
            type_r     <= 2'd0;
            tex_r      <= 4'd0;
            rem_r      <= 17'd0;
            quo_r      <= 18'd0;
            bit_r      <= 5'd0;
            sel_r      <= 2'd0;
            h_body_r   <= 12'd0;
            h_head_r   <= 12'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            prm_we_r   <= 1'b0;
            ray_addr_r <= 10'd0;
            prm_addr_r <= 10'd0;
            prm_data_r <= 43'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        col_r   <= 10'd0;
                        busy_r  <= 1'b1;
                        state_r <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ray_addr_r <= col_r;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    state_r <= S_LOAD;
                end
                S_LOAD: begin
                    dist_r <= ray_q[31:16];
                    type_r <= ray_q[1:0];
                    tex_r  <= tex_in_s;
                    rem_r  <= 17'd0;
                    quo_r  <= DVD_BODY;
                    bit_r  <= 5'd0;
                    sel_r  <= 2'd0;
                    if (ray_q[15:8] == 8'd0) begin
                        prm_we_r   <= 1'b1;
                        prm_addr_r <= col_r;
                        prm_data_r <= pack_word(1'b0, ray_q[1:0], tex_in_s, 12'd0, 12'd0, 12'd0);
                        state_r    <= S_WRITE;
                    end else if (ray_q[31:16] == 16'd0) begin
                        prm_we_r   <= 1'b1;
                        prm_addr_r <= col_r;
                        prm_data_r <= pack_word(1'b1, ray_q[1:0], tex_in_s, H_SAT, H_SAT, H_SAT);
                        state_r    <= S_WRITE;
                    end else begin
                        state_r <= S_DIV;
                    end
                end
                S_DIV: begin
                    if (last_bit_s) begin
                        rem_r <= 17'd0;
                        bit_r <= 5'd0;
                        case (sel_r)
                            2'd0: begin
                                h_body_r <= quot_sat_s;
                                quo_r    <= DVD_HEAD;
                                sel_r    <= 2'd1;
                            end
                            2'd1: begin
                                h_head_r <= quot_sat_s;
                                quo_r    <= DVD_ALL;
                                sel_r    <= 2'd2;
                            end
                            default: begin
                                prm_we_r   <= 1'b1;
                                prm_addr_r <= col_r;
                                prm_data_r <= pack_word(1'b1, type_r, tex_r, quot_sat_s, h_head_r, h_body_r);
                                sel_r      <= 2'd0;
                                state_r    <= S_WRITE;
                            end
                        endcase
                    end else begin
                        quo_r <= quot_s;
                        rem_r <= rem_next_s;
                        bit_r <= bit_r + 5'd1;
                    end
                end
                S_WRITE: begin
                    prm_we_r <= 1'b0;
                    if (col_r == LAST_COL) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        col_r   <= col_r + 10'd1;
                        state_r <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    prm_we_r <= 1'b0;
                    done_r   <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign ray_addr = ray_addr_r;
    assign prm_we   = prm_we_r;
    assign prm_addr = prm_addr_r;
    assign prm_data = prm_data_r;
endmodule

// File: tb/tb_mob_column_scheduler.sv
// Bench for mob_column_scheduler: directed vector table, randomized frames
// checked against an arithmetic reference, and reset/start corner sequences.
module tb_mob_column_scheduler;
    localparam int NCOL = 640;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, prm_we;
    logic [9:0]  ray_addr, prm_addr;
    logic [31:0] ray_q = 32'd0;
    logic [42:0] prm_data;

    logic [31:0] mem [0:1023];

    mob_column_scheduler dut (
        .Clk(Clk), .Reset(Reset), .start(start), .busy(busy), .done(done),
        .ray_addr(ray_addr), .ray_q(ray_q), .prm_we(prm_we),
        .prm_addr(prm_addr), .prm_data(prm_data)
    );

    always #5 Clk = ~Clk;

    // Ray RAM with one-cycle registered read.
    always @(posedge Clk) ray_q <= mem[ray_addr];

    int cyc = 0;
    int nwr = 0, ndone = 0, last_wr = 0, busy_rise = 0, done_cyc = 0, busy_fall = 0;
    logic busy_q = 1'b0;
    logic [42:0] cap_data [0:1023];
    logic [9:0]  cap_addr [0:1023];
    int          cap_gap  [0:1023];

    always @(posedge Clk) cyc <= cyc + 1;

    // Write/done monitor sampled on the falling edge.
    always @(negedge Clk) begin
        if (busy && !busy_q) busy_rise = cyc;
        if (!busy && busy_q) busy_fall = cyc;
        busy_q = busy;
        if (prm_we) begin
            if (nwr < 1024) begin
                cap_data[nwr] = prm_data;
                cap_addr[nwr] = prm_addr;
                cap_gap[nwr]  = (nwr == 0) ? (cyc - busy_rise + 1) : (cyc - last_wr);
            end
            last_wr = cyc;
            nwr++;
        end
        if (done) begin
            ndone++;
            done_cyc = cyc;
        end
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] hq(input int k, input int d);
        int q;
        q = k / d;
        return (q > 4095) ? 12'd4095 : 12'(q);
    endfunction

    function automatic logic [42:0] exp_word(input logic [31:0] r);
        int d;
        logic [3:0] tex;
        d   = int'(r[31:16]);
        tex = r[5:2] + 4'd8;
        if (r[15:8] == 8'd0) return {1'b0, r[1:0], tex, 36'd0};
        if (d == 0) return {1'b1, r[1:0], tex, 12'd4095, 12'd4095, 12'd4095};
        return {1'b1, r[1:0], tex, hq(163840, d), hq(40960, d), hq(122880, d)};
    endfunction

    function automatic int exp_gap(input logic [31:0] r);
        return (r[15:8] == 8'd0 || r[31:16] == 16'd0) ? 4 : 58;
    endfunction

    task automatic run_pass(input int budget, input int repulse_at, input bit poke_done);
        bit got;
        int n;
        @(posedge Clk); #1;
        nwr = 0;
        ndone = 0;
        @(negedge Clk);
        chk("busy_before_start", busy, 1'b0);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        got = 1'b0;
        n = 0;
        while (!got && n < budget) begin
            @(negedge Clk);
            n++;
            start = (n == repulse_at) ? 1'b1 : 1'b0;
            if (done) begin
                got = 1'b1;
                if (poke_done) begin
                    start = 1'b1;
                    @(posedge Clk); #1;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("pass_done_within_budget", got, 1'b1);
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_pass(input string tag);
        chk({tag, ":write_count"}, nwr, NCOL);
        chk({tag, ":done_count"}, ndone, 1);
        chk({tag, ":done_after_last_write"}, done_cyc - last_wr, 1);
        chk({tag, ":busy_fall_after_done"}, busy_fall - done_cyc, 1);
        chk({tag, ":busy_idle"}, busy, 1'b0);
        for (int i = 0; i < NCOL; i++) begin
            chk($sformatf("%s:addr[%0d]", tag, i), cap_addr[i], i);
            chk($sformatf("%s:data[%0d]", tag, i), cap_data[i], exp_word(mem[i]));
            chk($sformatf("%s:gap[%0d]", tag, i), cap_gap[i], exp_gap(mem[i]));
        end
    endtask

    typedef struct {
        logic [31:0] ray;
        logic        valid;
        logic [1:0]  typ;
        logic [3:0]  tex;
        logic [11:0] ha, hh, hb;
        int          gap;
    } vec_t;

    vec_t tbl [9];
    int   kind, n;
    logic [31:0] r;

    initial begin
        tbl[0] = '{32'h0100_0105, 1'b1, 2'd1, 4'd9,  12'd640,  12'd160,  12'd480,  58};
        tbl[1] = '{32'h0400_0200, 1'b1, 2'd0, 4'd8,  12'd160,  12'd40,   12'd120,  58};
        tbl[2] = '{32'h0003_073F, 1'b1, 2'd3, 4'd7,  12'd4095, 12'd4095, 12'd4095, 58};
        tbl[3] = '{32'h0000_0506, 1'b1, 2'd2, 4'd9,  12'd4095, 12'd4095, 12'd4095, 4};
        tbl[4] = '{32'hABCD_002A, 1'b0, 2'd2, 4'd2,  12'd0,    12'd0,    12'd0,    4};
        tbl[5] = '{32'hFFFF_FF00, 1'b1, 2'd0, 4'd8,  12'd2,    12'd0,    12'd1,    58};
        tbl[6] = '{32'h001E_0100, 1'b1, 2'd0, 4'd8,  12'd4095, 12'd1365, 12'd4095, 58};
        tbl[7] = '{32'h001F_0100, 1'b1, 2'd0, 4'd8,  12'd4095, 12'd1321, 12'd3963, 58};
        tbl[8] = '{32'h0028_0100, 1'b1, 2'd0, 4'd8,  12'd4095, 12'd1024, 12'd3072, 58};

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        repeat (3) @(negedge Clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_prm_we", prm_we, 1'b0);
        chk("reset_ray_addr", ray_addr, 10'd0);
        chk("reset_prm_addr", prm_addr, 10'd0);
        chk("reset_prm_data", prm_data, 43'd0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Directed table in the first columns, empty columns behind.
        for (int i = 0; i < 9; i++) mem[i] = tbl[i].ray;
        run_pass(4000, 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("tbl_word[%0d]", i), cap_data[i],
                {tbl[i].valid, tbl[i].typ, tbl[i].tex, tbl[i].ha, tbl[i].hh, tbl[i].hb});
            chk($sformatf("tbl_gap[%0d]", i), cap_gap[i], tbl[i].gap);
        end
        check_pass("table");

        // Randomized mixed frame with start re-pulsed twice mid-pass.
        for (int i = 0; i < NCOL; i++) begin
            kind = int'($urandom_range(0, 3));
            r = $urandom;
            case (kind)
                0: r[15:8] = 8'd0;
                1: begin r[31:16] = 16'd0; r[15:8] = 8'($urandom_range(1, 255)); end
                2: begin r[31:16] = 16'($urandom_range(1, 64)); r[15:8] = 8'($urandom_range(1, 255)); end
                default: begin
                    r[15:8] = 8'($urandom_range(1, 255));
                    if (r[31:16] == 16'd0) r[31:16] = 16'd1;
                end
            endcase
            mem[i] = r;
        end
        run_pass(NCOL * 58 + 200, 200, 1'b0);
        check_pass("random");
        run_pass(NCOL * 58 + 200, 5000, 1'b0);
        check_pass("random_repulse");

        // All-empty frame; start offered during the DONE cycle must be ignored.
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        run_pass(3000, 0, 1'b1);
        check_pass("empty");
        repeat (10) @(negedge Clk);
        chk("start_in_done_ignored_busy", busy, 1'b0);
        chk("start_in_done_ignored_writes", nwr, NCOL);

        // Asynchronous reset while column 100 is dividing.
        mem[100] = 32'h03E8_0A15;
        @(posedge Clk); #1;
        nwr = 0;
        @(negedge Clk); start = 1'b1;
        @(negedge Clk); start = 1'b0;
        n = 0;
        while (!(prm_we && prm_addr == 10'd99) && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        chk("reached_col99", n < 2000, 1'b1);
        repeat (14) @(negedge Clk);
        chk("busy_mid_div", busy, 1'b1);
        #1 Reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_done", done, 1'b0);
        chk("async_rst_prm_we", prm_we, 1'b0);
        chk("async_rst_ray_addr", ray_addr, 10'd0);
        chk("async_rst_prm_addr", prm_addr, 10'd0);
        chk("async_rst_prm_data", prm_data, 43'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        chk("writes_before_reset", nwr, 100);
        run_pass(4000, 0, 1'b0);
        check_pass("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mob_column_scheduler.md
Name: mob_column_scheduler

Overview:
- Per-frame precompute engine for the mob sprite colouring path.
- On each frame-start pulse it walks every screen column's ray entry in ray RAM and computes the three projected heights (body, head, whole mob) with one shared serial divider.
- Writes one packed parameter word per column into a column-parameter RAM, so the pixel path needs no combinational dividers.
- Runs during vertical blank; the pixel path reads the parameter RAM at scan time.

Parameters:
- NUM_COLS, 640, number of columns processed per frame (ray/param addresses 0..NUM_COLS-1)
- K_BODY, 122880, body height dividend
- K_HEAD, 40960, head height dividend
- K_ALL, 163840, whole-mob height dividend (must fit 18 bits)

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a frame pass when idle
- busy  out  1  high while a pass is in progress
- done  out  1  one-cycle pulse after the last column's parameter write
- ray_addr  out  10  ray RAM read address
- ray_q  in  32  ray RAM data, one-cycle registered read latency; [31:16] distance, [15:8] mob id (0 = no mob), [5:2] texture column, [1:0] mob type
- prm_we  out  1  parameter RAM write enable
- prm_addr  out  10  parameter RAM write address
- prm_data  out  43  [42] valid, [41:40] mob type, [39:36] texture column + 8 (mod 16), [35:24] h_all, [23:12] h_head, [11:0] h_body

Behaviour:
- Reset (asynchronous, at any time, including mid-pass):
  - state IDLE; busy, done, prm_we = 0; ray_addr, prm_addr, prm_data = 0.
  - No partial write completes.
- States: IDLE, FETCH, WAIT, LOAD, DIV, WRITE, DONE.
- IDLE: when start=1, column counter := 0, busy := 1, go to FETCH. start is ignored in every other state.
- FETCH: ray_addr := column counter; go to WAIT.
- WAIT: one cycle for RAM latency.
- LOAD: latch ray_q.
  - mob id == 0: go to WRITE with valid=0 and all height fields 0. No divide.
  - distance == 0 with mob id != 0: go to WRITE with valid=1 and all heights saturated to 4095. No divide.
  - Otherwise: select dividend K_BODY and go to DIV.
- DIV: restoring divider, 18-bit dividend, 16-bit divisor (distance), one quotient bit per cycle, exactly 18 cycles per quotient.
  - Dividends are processed in order K_BODY, K_HEAD, K_ALL.
  - After the third quotient, go to WRITE.
  - Each quotient is truncated integer division, saturated to 12 bits: any quotient > 4095 is stored as 4095.
- WRITE: single-cycle prm_we=1 with prm_addr = column counter and prm_data packed as above.
  - Texture field = ray_q[5:2] + 4'h8, wrapping mod 16.
  - If column counter == NUM_COLS-1, go to DONE. Otherwise increment the counter and go to FETCH.
- DONE: done=1 for one cycle, busy := 0, go to IDLE.
- Per-column latency:
  - Mob column: 58 cycles, FETCH to end of WRITE (1+1+1+54+1).
  - Empty column: 4 cycles.
  - A full pass of 640 mob columns takes 37120 cycles, plus 1 DONE cycle.
- prm_we is asserted only in WRITE; exactly NUM_COLS writes per pass, addresses strictly ascending 0..NUM_COLS-1, never wrapping.
- busy rises the cycle after start is sampled and falls in the cycle after done.
- start arriving in the same cycle as DONE is ignored (IDLE is not yet entered).

Test Plan:
- Column 0 ray_q = 0x0100_0105 (distance 256, id 1, tex 1, type 1) -> prm_data valid=1, type=1, tex=9, h_body=480, h_head=160, h_all=640; prm_we at cycle 58 after FETCH.
- Distance 1024, id 2 -> h_body=120, h_head=40, h_all=160. Distance 3 -> h_body=4095 (sat), h_head=4095 (13653 sat), h_all=4095.
- Mob id 0 at every column -> 640 writes, each valid=0 with zero heights, 4 cycles apart; done pulses once; busy low afterwards.
- Distance 0 with id 5 -> valid=1, all heights 4095, no DIV cycles (4-cycle column).
- Mixed frame, with start re-pulsed while busy -> pass not restarted; write addresses ascend 0..639 exactly once; done occurs exactly once.
- Reset asserted mid-DIV on column 100 -> outputs 0 immediately (asynchronous). A following start restarts from column 0 with correct results.
